// File: rtl/spi_pkg.sv
// Shared SPI constants and FSM state type, common to spi_phy and spi_slave_phy.
package spi_pkg;

  localparam int unsigned SPI_BYTE_W    = 8;
  localparam int unsigned SPI_BIT_CNT_W = 4;

  typedef enum logic {
    SPI_ST_IDLE   = 1'b0,
    SPI_ST_ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, with rise/fall pulses
// derived from the synchronised level.
module spi_sync_edge #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk_in,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain_q, chain_d;
  logic              prev_q, prev_d;

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d};
    prev_d  = chain_q[STAGES-1];
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      chain_q <= {STAGES{RESET_VAL}};
      prev_q  <= RESET_VAL;
    end else begin
      chain_q <= chain_d;
      prev_q  <= prev_d;
    end
  end

  assign q    = chain_q[STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_slave_phy.sv
// SPI mode-0 responder PHY, oversampled in the clk_in domain.
// SPI_SLAVE_OVERRUN_EN: byte_valid held until byte_ack, sticky overrun flag.
module spi_slave_phy
  import spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [SPI_BYTE_W-1:0] byte_in,
  output logic                  byte_written,
  output logic [SPI_BYTE_W-1:0] byte_out,
  output logic                  byte_valid,
  output logic                  busy
`ifdef SPI_SLAVE_OVERRUN_EN
  ,
  input  logic                  byte_ack,
  output logic                  overrun
`endif
);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
  logic sclk_s_unused, cs_s_unused, mosi_rise_unused, mosi_fall_unused;
  logic idle_byte_unused;

  assign idle_byte_unused = ^IDLE_BYTE;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk_in(clk_in), .reset(reset), .d(sclk),
    .q(sclk_s_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk_in(clk_in), .reset(reset), .d(cs),
    .q(cs_s_unused), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk_in(clk_in), .reset(reset), .d(mosi),
    .q(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  spi_state_e               state_q, state_d;
  logic [SPI_BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [SPI_BYTE_W-1:0]    rx_sr_q, rx_sr_d, tx_sr_q, tx_sr_d;
  logic [SPI_BYTE_W-1:0]    byte_out_q, byte_out_d;
  logic                     miso_q, miso_d, miso_oe_q, miso_oe_d;
  logic                     byte_valid_q, byte_valid_d;
  logic                     byte_written_q, byte_written_d;
  logic                     reload_pend_q, reload_pend_d;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic                     overrun_q, overrun_d;
`endif

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    rx_sr_d        = rx_sr_q;
    tx_sr_d        = tx_sr_q;
    byte_out_d     = byte_out_q;
    miso_d         = miso_q;
    miso_oe_d      = miso_oe_q;
    reload_pend_d  = reload_pend_q;
    byte_written_d = 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
    byte_valid_d   = byte_valid_q & ~byte_ack;
    overrun_d      = overrun_q;
`else
    byte_valid_d   = 1'b0;
`endif
    case (state_q)
      SPI_ST_IDLE: begin
        if (cs_fall && enable) begin
          state_d        = SPI_ST_ACTIVE;
          tx_sr_d        = byte_in;
          miso_d         = byte_in[SPI_BYTE_W-1];
          miso_oe_d      = 1'b1;
          byte_written_d = 1'b1;
          bit_cnt_d      = '0;
          reload_pend_d  = 1'b0;
        end
      end
      SPI_ST_ACTIVE: begin
        if (sclk_rise) begin
          rx_sr_d = {rx_sr_q[SPI_BYTE_W-2:0], mosi_s};
          if (bit_cnt_q == SPI_BIT_CNT_W'(SPI_BYTE_W - 1)) begin
            byte_out_d    = rx_sr_d;
            bit_cnt_d     = '0;
            reload_pend_d = 1'b1;
`ifdef SPI_SLAVE_OVERRUN_EN
            if (byte_valid_q && !byte_ack) overrun_d = 1'b1;
`endif
            byte_valid_d  = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        if (sclk_fall) begin
          if (reload_pend_q) begin
            tx_sr_d        = byte_in;
            miso_d         = byte_in[SPI_BYTE_W-1];
            byte_written_d = 1'b1;
            reload_pend_d  = 1'b0;
          end else begin
            tx_sr_d = {tx_sr_q[SPI_BYTE_W-2:0], 1'b0};
            miso_d  = tx_sr_q[SPI_BYTE_W-2];
          end
        end
        // Frame end overrides any same-cycle reload, but a completed byte still reports.
        if (cs_rise || !enable) begin
          state_d        = SPI_ST_IDLE;
          miso_d         = 1'b0;
          miso_oe_d      = 1'b0;
          bit_cnt_d      = '0;
          reload_pend_d  = 1'b0;
          byte_written_d = 1'b0;
        end
      end
      default: state_d = SPI_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q        <= SPI_ST_IDLE;
      bit_cnt_q      <= '0;
      rx_sr_q        <= '0;
      tx_sr_q        <= '0;
      byte_out_q     <= '0;
      miso_q         <= 1'b0;
      miso_oe_q      <= 1'b0;
      byte_valid_q   <= 1'b0;
      byte_written_q <= 1'b0;
      reload_pend_q  <= 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
      overrun_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      rx_sr_q        <= rx_sr_d;
      tx_sr_q        <= tx_sr_d;
      byte_out_q     <= byte_out_d;
      miso_q         <= miso_d;
      miso_oe_q      <= miso_oe_d;
      byte_valid_q   <= byte_valid_d;
      byte_written_q <= byte_written_d;
      reload_pend_q  <= reload_pend_d;
`ifdef SPI_SLAVE_OVERRUN_EN
      overrun_q      <= overrun_d;
`endif
    end
  end

  assign miso         = miso_q;
  assign miso_oe      = miso_oe_q;
  assign byte_out     = byte_out_q;
  assign byte_valid   = byte_valid_q;
  assign byte_written = byte_written_q;
  assign busy         = (state_q == SPI_ST_ACTIVE);
`ifdef SPI_SLAVE_OVERRUN_EN
  assign overrun      = overrun_q;
`endif

endmodule

// File: tb/tb_spi_slave_phy.sv
// Bench for spi_slave_phy: bus-functional mode-0 master, random frames, directed corner cases.
`timescale 1ns/1ps
module tb_spi_slave_phy;

  localparam int unsigned SYNC = 2;
  localparam int HALF = 50;

  logic clk_in = 1'b0, reset = 1'b1, enable = 1'b1;
  logic sclk = 1'b0, cs = 1'b1, mosi = 1'b0;
  logic miso, miso_oe, byte_written, byte_valid, busy;
  logic [7:0] byte_in = 8'h00, byte_out;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic byte_ack = 1'b0, overrun;
  bit   auto_ack = 1'b1, force_ack = 1'b0;
`endif

  spi_slave_phy #(.SYNC_STAGES(SYNC), .IDLE_BYTE(8'hFF)) dut (
    .clk_in(clk_in), .reset(reset), .enable(enable), .sclk(sclk), .cs(cs), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .byte_in(byte_in), .byte_written(byte_written),
    .byte_out(byte_out), .byte_valid(byte_valid), .busy(busy)
`ifdef SPI_SLAVE_OVERRUN_EN
    , .byte_ack(byte_ack), .overrun(overrun)
`endif
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: slave must receive exactly what the master sent, and the master must
  // receive the k-th byte_in the bench offered at the k-th byte_written.
  logic [7:0] m_tx[8], m_rx[8], bi_seq[8];
  logic [7:0] rx_q[$];
  int nv = 0, nw = 0, nw_base = 0, cnt_busy = 0, cnt_oe = 0, bad_miso = 0;

  always @(negedge clk_in) begin
    int idx;
    if (byte_valid) begin
      rx_q.push_back(byte_out);
      nv++;
    end
    if (byte_written) nw++;
    if (busy) cnt_busy++;
    if (miso_oe) cnt_oe++;
    if (!miso_oe && miso !== 1'b0) bad_miso++;
    idx = nw - nw_base;
    if (idx > 7) idx = 7;
    byte_in = bi_seq[idx];
`ifdef SPI_SLAVE_OVERRUN_EN
    byte_ack = (auto_ack && byte_valid) || force_ack;
`endif
  end

  task automatic master(input int nbytes, input int stop_after);
    int bits;
    logic [7:0] r;
    bits = 0;
    cs = 1'b0;
    for (int b = 0; b < nbytes; b++) begin
      r = '0;
      for (int i = 7; i >= 0; i--) begin
        mosi = m_tx[b][i];
        #(HALF) sclk = 1'b1;
        r = {r[6:0], miso};
        bits++;
        #(HALF);
        if (bits == stop_after || bits == nbytes * 8) begin
          sclk = 1'b0; cs = 1'b1; mosi = 1'b0;
          if (i == 0) m_rx[b] = r;
          return;
        end
        sclk = 1'b0;
      end
      m_rx[b] = r;
    end
  endtask

  int v0, w0, b0, o0;

  task automatic start_frame();
    @(negedge clk_in);
    nw_base = nw;
    v0 = nv; w0 = nw; b0 = cnt_busy; o0 = cnt_oe;
    @(negedge clk_in);
  endtask

  task automatic settle();
    repeat (12) @(posedge clk_in);
    @(negedge clk_in);
    #1;
  endtask

  task automatic full_frame(input string tag, input int nbytes);
    start_frame();
    master(nbytes, 0);
    settle();
    check({tag, "_nvalid"}, nv - v0, nbytes);
    check({tag, "_nwritten"}, nw - w0, nbytes);
    for (int b = 0; b < nbytes; b++) begin
      check({tag, "_rx"}, (v0 + b < rx_q.size()) ? rx_q[v0 + b] : 8'hxx, m_tx[b]);
      check({tag, "_miso"}, m_rx[b], bi_seq[b]);
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 8; i++) bi_seq[i] = 8'h00;
    repeat (3) @(posedge clk_in);
    #1 reset = 1'b0;
    @(negedge clk_in);
    check("rst_miso", miso, 0);
    check("rst_miso_oe", miso_oe, 0);
    check("rst_byte_out", byte_out, 0);
    check("rst_byte_valid", byte_valid, 0);
    check("rst_byte_written", byte_written, 0);
    check("rst_busy", busy, 0);

    // single byte
    m_tx[0] = 8'hA5; bi_seq[0] = 8'h3C;
    full_frame("t1", 1);
    check("t1_byte_out", byte_out, 8'hA5);

    // burst with alternating tx bytes
    m_tx[0] = 8'h01; m_tx[1] = 8'h02; m_tx[2] = 8'h03;
    for (int i = 0; i < 8; i++) bi_seq[i] = i[0] ? 8'hAA : 8'h55;
    full_frame("t2", 3);

    // abort after 5 rises
    m_tx[0] = 8'hF0; bi_seq[0] = 8'h99;
    start_frame();
    master(1, 5);
    repeat (SYNC + 2) @(posedge clk_in);
    #1 check("t3_oe_off", miso_oe, 0);
    settle();
    check("t3_nvalid", nv - v0, 0);
    check("t3_nwritten", nw - w0, 1);
    m_tx[0] = 8'hC3; bi_seq[0] = 8'h7E;
    full_frame("t3b", 1);

    // disabled
    enable = 1'b0;
    m_tx[0] = 8'hFF;
    start_frame();
    master(1, 0);
    settle();
    check("t4_nvalid", nv - v0, 0);
    check("t4_nwritten", nw - w0, 0);
    check("t4_busy", cnt_busy - b0, 0);
    check("t4_oe", cnt_oe - o0, 0);
    enable = 1'b1;

    // reset during byte 3 of a burst
    m_tx[0] = 8'h11; m_tx[1] = 8'h22; m_tx[2] = 8'h33;
    start_frame();
    master(3, 20);
    reset = 1'b1;
    @(posedge clk_in);
    #1;
    check("t5_miso", miso, 0);
    check("t5_miso_oe", miso_oe, 0);
    check("t5_byte_out", byte_out, 0);
    check("t5_byte_valid", byte_valid, 0);
    check("t5_byte_written", byte_written, 0);
    check("t5_busy", busy, 0);
    @(negedge clk_in);
    reset = 1'b0;
    m_tx[0] = 8'h5A; bi_seq[0] = 8'hC6;
    full_frame("t5b", 1);
    check("t5b_byte_out", byte_out, 8'h5A);

    // randomized frames
    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < 8; i++) begin
        m_tx[i] = 8'($urandom);
        bi_seq[i] = 8'($urandom);
      end
      full_frame("rnd", n);
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    auto_ack = 1'b0;
    m_tx[0] = 8'h6D; m_tx[1] = 8'hB2;
    start_frame();
    master(2, 0);
    settle();
    check("t6_byte_out", byte_out, 8'hB2);
    check("t6_valid_held", byte_valid, 1);
    check("t6_overrun", overrun, 1);
    force_ack = 1'b1;
    repeat (2) @(negedge clk_in);
    force_ack = 1'b0;
    repeat (2) @(negedge clk_in);
    #1;
    check("t6_valid_cleared", byte_valid, 0);
    check("t6_overrun_sticky", overrun, 1);
`endif

    check("miso_gated", bad_miso, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
